// File: rtl/keystroke_player.sv
// keystroke_player: plays a loaded script of keystroke words into a CPU
// keyboard port, one entry per step. Each entry is held for a fixed time or
// until the CPU acknowledges it. Playback can loop and can be aborted.
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_wr_en/addr/data   script write port, honoured only while not busy
//   i_length            entries to play, sampled with start; clamped to DEPTH
//   i_start, i_loop_en  begin playback; loop_en sampled with start
//   i_stop              abort playback
//   i_key_ack           CPU consumed key_data (handshake mode)
//   o_key_data          current keystroke word (IDLE_CODE when not valid)
//   o_key_valid         o_key_data holds a script entry
//   o_busy              playback in progress
//   o_done              one-cycle pulse when a non-looping play completes
//   o_index             entry currently presented
module keystroke_player #(
    parameter int unsigned          DATA_W      = 64,
    parameter int unsigned          DEPTH       = 64,
    parameter int unsigned          ADDR_W      = $clog2(DEPTH),
    parameter int unsigned          HOLD_CYCLES = 10,
    parameter bit                   HANDSHAKE   = 1'b0,
    parameter logic [DATA_W-1:0]    IDLE_CODE   = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [ADDR_W:0]     i_length,
    input  logic                i_start,
    input  logic                i_loop_en,
    input  logic                i_stop,
    input  logic                i_key_ack,
    output logic [DATA_W-1:0]   o_key_data,
    output logic                o_key_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W-1:0]   o_index
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [DATA_W-1:0]      r_data, w_data_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic [ADDR_W-1:0]      r_index, w_index_nxt;
    logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
    logic [LEN_W-1:0]       r_len, w_len_nxt;
    logic                   r_loop, w_loop_nxt;
    logic [LEN_W-1:0]       w_len_clamp;
    logic                   w_retire;
    logic                   w_last;

    // Script memory: no reset so a bring-up script survives a CPU reset
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !r_busy) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_len_clamp = (i_length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_length;
    assign w_last      = (r_index == ADDR_W'(r_len - LEN_W'(1)));
    // Current entry finishes at this edge: CPU ack, or hold time expired
    assign w_retire    = HANDSHAKE ? (r_valid && i_key_ack)
                                   : (r_hold == HOLD_W'(HOLD_CYCLES - 1));

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = IDLE_CODE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_index_nxt = r_index;
        w_hold_nxt  = r_hold;
        w_len_nxt   = r_len;
        w_loop_nxt  = r_loop;

        case (r_state)
            S_IDLE: begin
                // stop wins over start when both are raised in IDLE
                if (i_start && !i_stop) begin
                    w_len_nxt   = w_len_clamp;
                    w_loop_nxt  = i_loop_en;
                    w_index_nxt = '0;
                    w_hold_nxt  = '0;
                    if (w_len_clamp == '0) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_data_nxt  = r_mem[0];
                    end
                end
            end

            S_PLAY: begin
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                w_data_nxt  = r_mem[r_index];
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_data_nxt  = IDLE_CODE;
                    w_index_nxt = '0;
                    w_hold_nxt  = '0;
                end else if (w_retire) begin
                    w_hold_nxt = '0;
                    if (!w_last) begin
                        w_index_nxt = r_index + ADDR_W'(1);
                        w_data_nxt  = r_mem[r_index + ADDR_W'(1)];
                    end else if (r_loop) begin
                        w_index_nxt = '0;
                        w_data_nxt  = r_mem[0];
                    end else begin
                        w_state_nxt = S_FIN;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_data_nxt  = IDLE_CODE;
                        w_index_nxt = '0;
                    end
                end else if (!HANDSHAKE) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_data  <= IDLE_CODE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_index <= '0;
            r_hold  <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_index <= w_index_nxt;
            r_hold  <= w_hold_nxt;
            r_len   <= w_len_nxt;
            r_loop  <= w_loop_nxt;
        end
    end

    assign o_key_data  = r_data;
    assign o_key_valid = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_index     = r_index;

endmodule

// File: tb/tb_keystroke_player.sv
// Directed bench for keystroke_player: three instances (fixed hold 10,
// handshake, fixed hold 1) share the script port and control inputs but
// each has its own start strobe.
module tb_keystroke_player;

    localparam int unsigned       DW   = 16;
    localparam int unsigned       AW   = 6;
    localparam logic [DW-1:0]     IDLE = 16'hDEAD;
    localparam logic [DW-1:0]     KA   = 16'hAAAA;
    localparam logic [DW-1:0]     KB   = 16'hBBBB;
    localparam logic [DW-1:0]     KC   = 16'hCCCC;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, wr_en_fix;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   length;
    logic          start_fix, start_hs, start_h1;
    logic          loop_en, stop, key_ack;

    logic [DW-1:0] fix_data, hs_data, h1_data;
    logic          fix_valid, hs_valid, h1_valid;
    logic          fix_busy, hs_busy, h1_busy;
    logic          fix_done, hs_done, h1_done;
    logic [AW-1:0] fix_idx, hs_idx, h1_idx;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    keystroke_player #(.DATA_W(DW), .DEPTH(64), .HOLD_CYCLES(10), .HANDSHAKE(1'b0), .IDLE_CODE(IDLE)) u_fix (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en | wr_en_fix), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_length(length), .i_start(start_fix), .i_loop_en(loop_en),
        .i_stop(stop), .i_key_ack(key_ack), .o_key_data(fix_data), .o_key_valid(fix_valid),
        .o_busy(fix_busy), .o_done(fix_done), .o_index(fix_idx));

    keystroke_player #(.DATA_W(DW), .DEPTH(64), .HOLD_CYCLES(10), .HANDSHAKE(1'b1), .IDLE_CODE(IDLE)) u_hs (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_length(length), .i_start(start_hs), .i_loop_en(loop_en),
        .i_stop(stop), .i_key_ack(key_ack), .o_key_data(hs_data), .o_key_valid(hs_valid),
        .o_busy(hs_busy), .o_done(hs_done), .o_index(hs_idx));

    keystroke_player #(.DATA_W(DW), .DEPTH(64), .HOLD_CYCLES(1), .HANDSHAKE(1'b0), .IDLE_CODE(IDLE)) u_h1 (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_length(length), .i_start(start_h1), .i_loop_en(loop_en),
        .i_stop(stop), .i_key_ack(key_ack), .o_key_data(h1_data), .o_key_valid(h1_valid),
        .o_busy(h1_busy), .o_done(h1_done), .o_index(h1_idx));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Script contents loaded below: A,B,C then 0x0100+i
    function automatic logic [DW-1:0] entry(input int i);
        if (i == 0) return KA;
        if (i == 1) return KB;
        if (i == 2) return KC;
        return DW'(16'h0100 + i);
    endfunction

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_en_fix = 1'b0; wr_addr = '0; wr_data = '0;
        length = '0; start_fix = 1'b0; start_hs = 1'b0; start_h1 = 1'b0;
        loop_en = 1'b0; stop = 1'b0; key_ack = 1'b0;
        #12;
        chk("rst_valid", 64'(fix_valid), 64'd0);
        chk("rst_data",  64'(fix_data),  64'(IDLE));
        chk("rst_busy",  64'(hs_busy),   64'd0);
        chk("rst_done",  64'(h1_done),   64'd0);
        chk("rst_index", 64'(fix_idx),   64'd0);
        reset = 1'b0;
        tick();

        // Load the whole script into all three instances
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = entry(i);
            tick();
        end
        wr_en = 1'b0;

        // T1: fixed hold of 10, three entries
        length = 7'd3; loop_en = 1'b0; start_fix = 1'b1;
        tick();
        start_fix = 1'b0;
        for (int c = 0; c < 30; c++) begin
            chk("t1_data",  64'(fix_data),  64'(entry(c / 10)));
            chk("t1_valid", 64'(fix_valid), 64'd1);
            chk("t1_busy",  64'(fix_busy),  64'd1);
            tick();
        end
        chk("t1_done",     64'(fix_done),  64'd1);
        chk("t1_end_vld",  64'(fix_valid), 64'd0);
        chk("t1_end_data", 64'(fix_data),  64'(IDLE));
        chk("t1_end_busy", 64'(fix_busy),  64'd0);
        tick();
        chk("t1_done_1cy", 64'(fix_done),  64'd0);

        // T2: handshake, ack in the 4th and 5th cycles after start
        length = 7'd2; start_hs = 1'b1;
        tick();
        start_hs = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t2_e0_data", 64'(hs_data), 64'(KA));
            chk("t2_e0_idx",  64'(hs_idx),  64'd0);
            if (c == 3) key_ack = 1'b1;
            tick();
        end
        chk("t2_e1_data", 64'(hs_data), 64'(KB));
        chk("t2_e1_idx",  64'(hs_idx),  64'd1);
        tick();
        key_ack = 1'b0;
        chk("t2_done",  64'(hs_done),  64'd1);
        chk("t2_valid", 64'(hs_valid), 64'd0);
        tick();
        chk("t2_done_1cy", 64'(hs_done), 64'd0);

        // T3: looping with hold 1, then stop
        length = 7'd2; loop_en = 1'b1; start_h1 = 1'b1;
        tick();
        start_h1 = 1'b0; loop_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("t3_data", 64'(h1_data), 64'(entry(c % 2)));
            chk("t3_done", 64'(h1_done), 64'd0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_vld",  64'(h1_valid), 64'd0);
        chk("t3_stop_done", 64'(h1_done),  64'd0);
        chk("t3_stop_busy", 64'(h1_busy),  64'd0);
        chk("t3_stop_data", 64'(h1_data),  64'(IDLE));
        tick();
        chk("t3_no_done", 64'(h1_done), 64'd0);

        // start together with stop in IDLE is ignored
        length = 7'd2; start_h1 = 1'b1; stop = 1'b1;
        tick();
        start_h1 = 1'b0; stop = 1'b0;
        chk("ss_busy",  64'(h1_busy),  64'd0);
        chk("ss_valid", 64'(h1_valid), 64'd0);

        // T4: zero length
        length = 7'd0; start_h1 = 1'b1;
        tick();
        start_h1 = 1'b0;
        chk("t4_valid", 64'(h1_valid), 64'd0);
        chk("t4_done",  64'(h1_done),  64'd1);
        chk("t4_busy",  64'(h1_busy),  64'd0);
        tick();
        chk("t4_done_1cy", 64'(h1_done),  64'd0);
        chk("t4_valid2",   64'(h1_valid), 64'd0);

        // T5: length 100 clamps to 64 entries
        length = 7'd100; start_h1 = 1'b1;
        tick();
        start_h1 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            chk("t5_data", 64'(h1_data), 64'(entry(c)));
            chk("t5_idx",  64'(h1_idx),  64'(c));
            tick();
        end
        chk("t5_done",  64'(h1_done),  64'd1);
        chk("t5_valid", 64'(h1_valid), 64'd0);

        // T6: write while busy is dropped, async reset mid entry 2
        length = 7'd3; start_fix = 1'b1;
        tick();
        start_fix = 1'b0;
        repeat (24) tick();
        chk("t6_e2_data", 64'(fix_data), 64'(KC));
        wr_en_fix = 1'b1; wr_addr = '0; wr_data = 16'h1234;
        tick();
        wr_en_fix = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_vld",  64'(fix_valid), 64'd0);
        chk("t6_rst_data", 64'(fix_data),  64'(IDLE));
        chk("t6_rst_busy", 64'(fix_busy),  64'd0);
        chk("t6_rst_idx",  64'(fix_idx),   64'd0);
        #2 reset = 1'b0;
        tick();
        chk("t6_no_auto", 64'(fix_valid), 64'd0);
        length = 7'd3; start_fix = 1'b1;
        tick();
        start_fix = 1'b0;
        chk("t6_replay_a", 64'(fix_data), 64'(KA));
        repeat (10) tick();
        chk("t6_replay_b", 64'(fix_data), 64'(KB));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t6_stop_vld", 64'(fix_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
